// File: rtl/jtag_tap_multi_pkg.sv
// Shared TAP definitions: 16-state controller encoding, DR selection, instruction codes.
// Optional feature macro used by the top: JTAG_TAP_SAMPLE_EN.
package jtag_tap_multi_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } jtag_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_SAMPLE,
    DR_USER
  } dr_sel_t;

  localparam logic [31:0] SAMPLE_PATTERN  = 32'h5555_5555;
  localparam logic [1:0]  IR_CAPTURE_LSBS = 2'b01;

  function automatic logic [31:0] instr_sample();
    return '0;
  endfunction

  function automatic logic [31:0] instr_idcode();
    return 32'd1;
  endfunction

  function automatic logic [31:0] instr_user(input int unsigned k);
    return 32'd2 + k;
  endfunction

  function automatic logic [31:0] instr_bypass(input int unsigned ir_width);
    return (ir_width >= 32) ? '1 : ((32'd1 << ir_width) - 32'd1);
  endfunction

  function automatic int unsigned dr_max_width(input int unsigned user_width);
    return (user_width > 32) ? user_width : 32;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller with strobes that fire on entry to key states.
module jtag_tap_fsm
  import jtag_tap_multi_pkg::*;
(
  input  logic        tclk,
  input  logic        trst,
  input  logic        tms,
  output jtag_state_t state,
  output logic        enter_tlr,
  output logic        enter_capture_dr,
  output logic        enter_update_dr,
  output logic        enter_capture_ir,
  output logic        enter_update_ir
);

  jtag_state_t state_q, state_d;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) state_q <= TEST_LOGIC_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Strobes decode the next state so their effects land on the entering edge.
  always_comb begin
    state            = state_q;
    enter_tlr        = (state_d == TEST_LOGIC_RESET);
    enter_capture_dr = (state_d == CAPTURE_DR);
    enter_update_dr  = (state_d == UPDATE_DR);
    enter_capture_ir = (state_d == CAPTURE_IR);
    enter_update_ir  = (state_d == UPDATE_IR);
  end

endmodule

// File: rtl/jtag_tap_multi.sv
// Parametrised TAP: IR, IDCODE/BYPASS/USER_k data registers and per-channel strobes.
// Define JTAG_TAP_SAMPLE_EN to make the all-zeros instruction capture SAMPLE_PATTERN.
module jtag_tap_multi
  import jtag_tap_multi_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 6,
  parameter logic [31:0] IDCODE_VAL    = 32'h1BEEF001,
  parameter int unsigned N_USER        = 2,
  parameter int unsigned USER_DR_WIDTH = 32
) (
  input  logic                              tclk,
  input  logic                              trst,
  input  logic                              tms,
  input  logic                              tdi,
  output logic                              tdo,
  output logic                              tdo_en,
  input  logic [N_USER*USER_DR_WIDTH-1:0]   user_capture_data,
  input  logic [N_USER-1:0]                 user_busy,
  output logic [N_USER-1:0]                 user_capture,
  output logic [N_USER-1:0]                 user_update,
  output logic [USER_DR_WIDTH-1:0]          user_update_data
);

  localparam int unsigned DR_W  = dr_max_width(USER_DR_WIDTH);
  localparam int unsigned IDX_W = (N_USER > 1) ? $clog2(N_USER) : 1;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_WIDTH'(instr_idcode());
  localparam logic [IR_WIDTH-1:0] IR_USER0    = IR_WIDTH'(instr_user(0));
  localparam logic [IR_WIDTH-1:0] IR_USER_END = IR_WIDTH'(instr_user(N_USER));
`ifdef JTAG_TAP_SAMPLE_EN
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE   = IR_WIDTH'(instr_sample());
`endif

  jtag_state_t state;
  logic        enter_tlr, enter_capture_dr, enter_update_dr;
  logic        enter_capture_ir, enter_update_ir;
  logic        in_shift_dr, in_shift_ir;

  jtag_tap_fsm u_fsm (
    .tclk             (tclk),
    .trst             (trst),
    .tms              (tms),
    .state            (state),
    .enter_tlr        (enter_tlr),
    .enter_capture_dr (enter_capture_dr),
    .enter_update_dr  (enter_update_dr),
    .enter_capture_ir (enter_capture_ir),
    .enter_update_ir  (enter_update_ir)
  );

  logic [IR_WIDTH-1:0]      ir_q, ir_d;
  logic [IR_WIDTH-1:0]      ir_shift_q, ir_shift_d;
  logic [DR_W-1:0]          dr_q, dr_d;
  logic                     overrun_q, overrun_d;
  logic [N_USER-1:0]        user_capture_q, user_capture_d;
  logic [N_USER-1:0]        user_update_q, user_update_d;
  logic [USER_DR_WIDTH-1:0] user_update_data_q, user_update_data_d;

  // Unlisted codes, including all-ones, fall through to BYPASS.
  function automatic dr_sel_t decode_sel(input logic [IR_WIDTH-1:0] code);
    decode_sel = DR_BYPASS;
    if (code == IR_IDCODE) decode_sel = DR_IDCODE;
`ifdef JTAG_TAP_SAMPLE_EN
    if (code == IR_SAMPLE) decode_sel = DR_SAMPLE;
`endif
    if (code >= IR_USER0 && code < IR_USER_END) decode_sel = DR_USER;
  endfunction

  dr_sel_t          dr_sel;
  logic [IDX_W-1:0] user_idx;
  logic [DR_W-1:0]  dr_capture;
  logic             ovr_set, ovr_clr;

  always_comb begin
    dr_sel      = decode_sel(ir_q);
    user_idx    = (dr_sel == DR_USER) ? IDX_W'(ir_q - IR_USER0) : '0;
    in_shift_dr = (state == SHIFT_DR);
    in_shift_ir = (state == SHIFT_IR);
    case (dr_sel)
      DR_IDCODE: dr_capture = DR_W'(IDCODE_VAL);
      DR_SAMPLE: dr_capture = DR_W'(SAMPLE_PATTERN);
      DR_USER:   dr_capture = DR_W'(user_capture_data[user_idx*USER_DR_WIDTH +: USER_DR_WIDTH]);
      default:   dr_capture = '0;
    endcase
  end

  always_comb begin
    ir_d               = ir_q;
    ir_shift_d         = ir_shift_q;
    dr_d               = dr_q;
    overrun_d          = overrun_q;
    user_capture_d     = '0;
    user_update_d      = '0;
    user_update_data_d = user_update_data_q;
    ovr_set            = 1'b0;
    ovr_clr            = 1'b0;

    // Capture zero-extends, so plain right shift keeps bits above the effective length clear.
    if (enter_capture_dr) begin
      dr_d = dr_capture;
      if (dr_sel == DR_USER) user_capture_d[user_idx] = 1'b1;
    end else if (in_shift_dr) begin
      dr_d = dr_q >> 1;
      case (dr_sel)
        DR_USER:              dr_d[USER_DR_WIDTH-1] = tdi;
        DR_IDCODE, DR_SAMPLE: dr_d[31]              = tdi;
        default:              dr_d[0]               = tdi;
      endcase
    end

    if (enter_update_dr && dr_sel == DR_USER) begin
      if (user_busy[user_idx]) begin
        ovr_set = 1'b1;
      end else begin
        user_update_d[user_idx] = 1'b1;
        user_update_data_d      = dr_q[USER_DR_WIDTH-1:0];
      end
    end

    if (enter_capture_ir) begin
      ir_shift_d = IR_WIDTH'({overrun_q, IR_CAPTURE_LSBS});
    end else if (in_shift_ir) begin
      ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
    end

    if (enter_update_ir) begin
      ir_d = ir_shift_q;
      if (decode_sel(ir_shift_q) == DR_BYPASS) ovr_clr = 1'b1;
    end
    if (enter_tlr) begin
      ir_d    = IR_IDCODE;
      ovr_clr = 1'b1;
    end

    if (ovr_set)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir_q               <= IR_IDCODE;
      ir_shift_q         <= '0;
      dr_q               <= '0;
      overrun_q          <= 1'b0;
      user_capture_q     <= '0;
      user_update_q      <= '0;
      user_update_data_q <= '0;
    end else begin
      ir_q               <= ir_d;
      ir_shift_q         <= ir_shift_d;
      dr_q               <= dr_d;
      overrun_q          <= overrun_d;
      user_capture_q     <= user_capture_d;
      user_update_q      <= user_update_d;
      user_update_data_q <= user_update_data_d;
    end
  end

  always_comb begin
    tdo_en           = in_shift_dr | in_shift_ir;
    tdo              = in_shift_ir ? ir_shift_q[0] : (in_shift_dr ? dr_q[0] : 1'b0);
    user_capture     = user_capture_q;
    user_update      = user_update_q;
    user_update_data = user_update_data_q;
  end

endmodule
